// File: rtl/mux_arb_nto1_if.sv
// Handshake bundle for mux_arb_nto1: NUM_IN producer channels in, one registered beat out.
// The per-channel mux_in_last bits exist only when MUX_ARB_LOCK_EN is defined.
interface mux_arb_nto1_if #(
  parameter int DWIDTH = 32,
  parameter int NUM_IN = 4
);
  localparam int SEL_W = $clog2(NUM_IN);

  logic [NUM_IN*DWIDTH-1:0] mux_in_data;
  logic [NUM_IN-1:0]        mux_in_valid;
  logic [NUM_IN-1:0]        mux_in_ready;
`ifdef MUX_ARB_LOCK_EN
  logic [NUM_IN-1:0]        mux_in_last;
`endif
  logic [DWIDTH-1:0]        mux_out;
  logic                     mux_out_valid;
  logic                     mux_out_ready;
  logic [SEL_W-1:0]         mux_out_sel;

`ifdef MUX_ARB_LOCK_EN
  modport slave (
    input  mux_in_data, mux_in_valid, mux_in_last, mux_out_ready,
    output mux_in_ready, mux_out, mux_out_valid, mux_out_sel
  );
  modport master (
    output mux_in_data, mux_in_valid, mux_in_last, mux_out_ready,
    input  mux_in_ready, mux_out, mux_out_valid, mux_out_sel
  );
`else
  modport slave (
    input  mux_in_data, mux_in_valid, mux_out_ready,
    output mux_in_ready, mux_out, mux_out_valid, mux_out_sel
  );
  modport master (
    output mux_in_data, mux_in_valid, mux_out_ready,
    input  mux_in_ready, mux_out, mux_out_valid, mux_out_sel
  );
`endif
endinterface

// File: rtl/mux_arb_nto1.sv
// Registered N:1 arbitrated mux: fixed-priority or round-robin grant into a single output register.
// Define MUX_ARB_LOCK_EN to hold the grant on one channel until a beat with last=1 is accepted.
module mux_arb_nto1 #(
  parameter int DWIDTH = 32,
  parameter int NUM_IN = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mode_sel,
  mux_arb_nto1_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_IN);

  logic [SEL_W-1:0]  ptr;
  logic              fp_any, rr_any, gnt_any;
  logic [SEL_W-1:0]  fp_idx, rr_idx, gnt_idx;
  logic [NUM_IN-1:0] grant;
  logic [DWIDTH-1:0] sel_data;
  logic              load_en, xfer, ptr_upd;

  function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] idx);
    return (idx == SEL_W'(NUM_IN-1)) ? '0 : idx + 1'b1;
  endfunction

  assign load_en = !bus.mux_out_valid || bus.mux_out_ready;

  // Both candidate winners are computed every cycle; mode_sel only picks between them.
  always_comb begin
    int c;
    c      = 0;
    fp_any = 1'b0;
    fp_idx = '0;
    rr_any = 1'b0;
    rr_idx = '0;
    for (int i = NUM_IN-1; i >= 0; i--) begin
      if (bus.mux_in_valid[i]) begin
        fp_any = 1'b1;
        fp_idx = SEL_W'(i);
      end
    end
    for (int k = NUM_IN-1; k >= 0; k--) begin
      c = int'(ptr) + k;
      if (c >= NUM_IN) c = c - NUM_IN;
      if (bus.mux_in_valid[c]) begin
        rr_any = 1'b1;
        rr_idx = SEL_W'(c);
      end
    end
  end

`ifdef MUX_ARB_LOCK_EN
  typedef enum logic {ST_OPEN, ST_LOCKED} lock_state_t;
  lock_state_t      state, state_nxt;
  logic [SEL_W-1:0] lock_idx, lock_idx_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_OPEN;
      lock_idx <= '0;
    end else begin
      state    <= state_nxt;
      lock_idx <= lock_idx_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    lock_idx_nxt = lock_idx;
    if (xfer) begin
      if (bus.mux_in_last[gnt_idx]) begin
        state_nxt = ST_OPEN;
      end else begin
        state_nxt    = ST_LOCKED;
        lock_idx_nxt = gnt_idx;
      end
    end
  end

  // A locked channel that drops valid stalls the arbiter rather than releasing it.
  always_comb begin
    if (state == ST_LOCKED) begin
      gnt_any = bus.mux_in_valid[lock_idx];
      gnt_idx = lock_idx;
    end else begin
      gnt_any = mode_sel ? rr_any : fp_any;
      gnt_idx = mode_sel ? rr_idx : fp_idx;
    end
  end

  assign ptr_upd = xfer && bus.mux_in_last[gnt_idx];
`else
  always_comb begin
    gnt_any = mode_sel ? rr_any : fp_any;
    gnt_idx = mode_sel ? rr_idx : fp_idx;
  end

  assign ptr_upd = xfer;
`endif

  assign xfer = load_en && gnt_any;

  always_comb begin
    grant    = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (SEL_W'(i) == gnt_idx) begin
        grant[i] = gnt_any;
        sel_data = bus.mux_in_data[i*DWIDTH +: DWIDTH];
      end
    end
  end

  // Ready is forced low while reset is held, independent of the register state.
  assign bus.mux_in_ready = (rst_n && load_en) ? grant : '0;

  // Output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mux_out       <= '0;
      bus.mux_out_valid <= 1'b0;
      bus.mux_out_sel   <= '0;
      ptr               <= '0;
    end else begin
      if (load_en) begin
        bus.mux_out_valid <= gnt_any;
        if (gnt_any) begin
          bus.mux_out     <= sel_data;
          bus.mux_out_sel <= gnt_idx;
        end
      end
      if (ptr_upd) ptr <= next_ptr(gnt_idx);
    end
  end
endmodule

// File: tb/tb_mux_arb_nto1.sv
// Randomized and directed bench for mux_arb_nto1 against a queue-free cycle-level reference model.
// Lock-mode checks are compiled in when MUX_ARB_LOCK_EN is defined.
module tb_mux_arb_nto1;
  localparam int DW = 32;
  localparam int N  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mode_sel = 1'b0;
  always #5 clk = ~clk;

  mux_arb_nto1_if #(.DWIDTH(DW), .NUM_IN(N)) bus ();
  mux_arb_nto1 #(.DWIDTH(DW), .NUM_IN(N)) dut (
    .clk(clk), .rst_n(rst_n), .mode_sel(mode_sel), .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic          m_valid;
  logic [DW-1:0] m_out;
  int            m_sel, m_ptr, m_lock_ch;
  bit            m_lock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic reset_model();
    m_valid = 1'b0; m_out = '0; m_sel = 0; m_ptr = 0; m_lock = 1'b0; m_lock_ch = 0;
  endtask

  // Winner from the arbitration rules: lowest valid index, or first valid at/after the pointer.
  function automatic int pick();
    int c;
    if (m_lock) return bus.mux_in_valid[m_lock_ch] ? m_lock_ch : -1;
    for (int k = 0; k < N; k++) begin
      c = mode_sel ? (m_ptr + k) % N : k;
      if (bus.mux_in_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic set_data(input int ch, input logic [DW-1:0] v);
    bus.mux_in_data[ch*DW +: DW] = v;
  endtask

  // Inputs are already applied; checks ready mid-cycle, steps the model at the edge, checks outputs.
  task automatic cycle();
    int g;
    bit ld;
    logic [N-1:0] er;
    g  = pick();
    ld = !m_valid || bus.mux_out_ready;
    er = (ld && g >= 0) ? (N'(1) << g) : '0;
    #1;
    check("in_ready", 64'(bus.mux_in_ready), 64'(er));
    @(posedge clk);
    if (ld) begin
      if (g >= 0) begin
        m_out   = bus.mux_in_data[g*DW +: DW];
        m_sel   = g;
        m_valid = 1'b1;
`ifdef MUX_ARB_LOCK_EN
        if (!bus.mux_in_last[g]) begin
          m_lock = 1'b1; m_lock_ch = g;
        end else begin
          m_lock = 1'b0; m_ptr = (g + 1) % N;
        end
`else
        m_ptr = (g + 1) % N;
`endif
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    check("out_valid", 64'(bus.mux_out_valid), 64'(m_valid));
    check("out", 64'(bus.mux_out), 64'(m_out));
    check("out_sel", 64'(bus.mux_out_sel), 64'(m_sel));
  endtask

  // Drops reset between edges and checks the outputs react without a clock.
  task automatic async_reset();
    bus.mux_in_valid  = '1;
    bus.mux_out_ready = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    reset_model();
    check("rst_out_valid", 64'(bus.mux_out_valid), 64'd0);
    check("rst_out", 64'(bus.mux_out), 64'd0);
    check("rst_out_sel", 64'(bus.mux_out_sel), 64'd0);
    check("rst_in_ready", 64'(bus.mux_in_ready), 64'd0);
    bus.mux_in_valid = '0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_valid", 64'(bus.mux_out_valid), 64'd0);
  endtask

  initial begin
    bus.mux_in_data   = '0;
    bus.mux_in_valid  = '1;
    bus.mux_out_ready = 1'b1;
`ifdef MUX_ARB_LOCK_EN
    bus.mux_in_last   = '1;
`endif
    reset_model();
    #12;
    check("init_in_ready", 64'(bus.mux_in_ready), 64'd0);
    check("init_out_valid", 64'(bus.mux_out_valid), 64'd0);
    check("init_out", 64'(bus.mux_out), 64'd0);
    bus.mux_in_valid = '0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Stream a beat of 0x11, then reset asynchronously mid-operation.
    mode_sel = 1'b0;
    set_data(0, 32'h11);
    bus.mux_in_valid = 4'b0001;
    cycle();
    check("pre_rst_out", 64'(bus.mux_out), 64'h11);
    async_reset();

    // Round-robin from pointer 0 with all channels valid.
    mode_sel = 1'b1;
    for (int i = 0; i < N; i++) set_data(i, 32'hA0 + i);
    bus.mux_in_valid  = 4'b1111;
    bus.mux_out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("rr_out", 64'(bus.mux_out), 64'(32'hA0 + (k % N)));
      check("rr_sel", 64'(bus.mux_out_sel), 64'(k % N));
    end

    // Fixed priority with channels 1 and 3 valid: channel 1 always wins.
    mode_sel = 1'b0;
    bus.mux_in_valid = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("fp_ready", 64'(bus.mux_in_ready), 64'b0010);
      cycle();
      check("fp_sel", 64'(bus.mux_out_sel), 64'd1);
    end

    // Backpressure holds 0x11 while channel 2 waits, then loads 0x22 with no gap.
    set_data(0, 32'h11);
    bus.mux_in_valid = 4'b0001;
    cycle();
    bus.mux_out_ready = 1'b0;
    set_data(2, 32'h22);
    bus.mux_in_valid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_ready", 64'(bus.mux_in_ready), 64'd0);
      cycle();
      check("bp_hold", 64'(bus.mux_out), 64'h11);
    end
    bus.mux_out_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(bus.mux_in_ready), 64'b0100);
    cycle();
    check("bp_release_out", 64'(bus.mux_out), 64'h22);

    // Empty drain keeps data and sel.
    set_data(1, 32'h33);
    bus.mux_in_valid = 4'b0010;
    cycle();
    bus.mux_in_valid = 4'b0000;
    cycle();
    check("drain_valid", 64'(bus.mux_out_valid), 64'd0);
    check("drain_out", 64'(bus.mux_out), 64'h33);
    check("drain_sel", 64'(bus.mux_out_sel), 64'd1);

`ifdef MUX_ARB_LOCK_EN
    // Channel 1 sends a three-beat packet with a valid gap; channel 2 follows.
    async_reset();
    mode_sel = 1'b1;
    bus.mux_in_last  = '1;
    bus.mux_in_valid = 4'b0001;
    cycle();
    bus.mux_in_valid   = 4'b1111;
    bus.mux_in_last[1] = 1'b0;
    cycle();
    check("lock_beat0", 64'(bus.mux_out_sel), 64'd1);
    bus.mux_in_valid = 4'b1101;
    #1;
    check("lock_gap_ready", 64'(bus.mux_in_ready), 64'd0);
    cycle();
    bus.mux_in_valid = 4'b1111;
    cycle();
    check("lock_beat1", 64'(bus.mux_out_sel), 64'd1);
    bus.mux_in_last[1] = 1'b1;
    cycle();
    check("lock_beat2", 64'(bus.mux_out_sel), 64'd1);
    cycle();
    check("lock_next", 64'(bus.mux_out_sel), 64'd2);
`endif

    // Random traffic with occasional mode flips.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) set_data(i, $urandom);
      bus.mux_in_valid  = N'($urandom);
      bus.mux_out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) mode_sel = ~mode_sel;
`ifdef MUX_ARB_LOCK_EN
      bus.mux_in_last = N'($urandom);
`endif
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
